// File: rtl/ser_frame_feeder_if.sv
// Word-in / bit-out bundle for the serial frame feeder.
// The master drives words in; the slave returns handshake ready and the serial stream.
interface ser_frame_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic             frame_end;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid,
    input  frame_start, frame_end
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid,
    output frame_start, frame_end
  );
endinterface

// File: rtl/ser_frame_feeder.sv
// Serializes handshaked words onto x, one bit per clock, with frame markers.
// Define PARITY_BIT_EN to append an even-parity bit to every frame.
module ser_frame_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  ser_frame_feeder_if.slave        bus
);

`ifdef PARITY_BIT_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_left;
  logic             r_x;
  logic             r_x_valid;
  logic             r_fs;
  logic             r_fe;

  logic [WIDTH-1:0] w_ord;
  logic             w_ready;
  logic             w_xfer;
  logic             w_tail;

  // Reorder so the next bit to send always sits at the top.
  always_comb begin
    w_ord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ord[i] = MSB_FIRST ? bus.din[i]
                           : bus.din[WIDTH-1-i];
    end
  end

`ifdef PARITY_BIT_EN
  assign w_tail = ^bus.din;
`else
  assign w_tail = 1'b0;
`endif

  assign w_ready = !rst &&
                   ((r_state == IDLE) ||
                    (r_left == '0));
  assign w_xfer  = bus.din_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_left    <= '0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_fs      <= 1'b0;
      r_fe      <= 1'b0;
    end else if (w_xfer) begin
      r_state   <= SHIFT;
      r_x       <= w_ord[WIDTH-1];
      r_sh      <= {w_ord[WIDTH-2:0], w_tail};
      r_left    <= CW'(FLEN - 1);
      r_x_valid <= 1'b1;
      r_fs      <= 1'b1;
      r_fe      <= 1'b0;
    end else if (r_state == SHIFT &&
                 r_left != '0) begin
      r_x    <= r_sh[WIDTH-1];
      r_sh   <= r_sh << 1;
      r_left <= r_left - CW'(1);
      r_fs   <= 1'b0;
      r_fe   <= (r_left == CW'(1));
    end else begin
      r_state   <= IDLE;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_fs      <= 1'b0;
      r_fe      <= 1'b0;
    end
  end

  assign bus.din_ready   = w_ready;
  assign bus.x           = r_x;
  assign bus.x_valid     = r_x_valid;
  assign bus.frame_start = r_fs;
  assign bus.frame_end   = r_fe;

endmodule

// File: tb/tb_ser_frame_feeder.sv
// Bench for ser_frame_feeder: MSB-first and LSB-first instances
// share one stimulus stream and are checked against a frame-queue model.
module tb_ser_frame_feeder;

`ifdef PARITY_BIT_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  typedef struct packed {
    logic v;
    logic x;
    logic fs;
    logic fe;
  } obit_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic [7:0] din;

  int n_cmp = 0;
  int n_err = 0;

  obit_t q_m[$];
  obit_t q_l[$];
  obit_t cur_m;
  obit_t cur_l;

  always #5 clk = ~clk;

  ser_frame_feeder_if #(.WIDTH(8)) bm ();
  ser_frame_feeder_if #(.WIDTH(8)) bl ();

  assign bm.din       = din;
  assign bm.din_valid = din_valid;
  assign bl.din       = din;
  assign bl.din_valid = din_valid;

  ser_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk (clk),
    .rst (rst),
    .bus (bm.slave)
  );

  ser_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk (clk),
    .rst (rst),
    .bus (bl.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic obit_t frame_bit(input logic [7:0] d,
                                      input bit msb,
                                      input int k);
    obit_t b;
    b.v  = 1'b1;
    if (k < 8) b.x = msb ? d[7-k] : d[k];
    else       b.x = ^d;
    b.fs = (k == 0);
    b.fe = (k == FLEN - 1);
    return b;
  endfunction

  task automatic chk_out(input string who,
                         input obit_t exp,
                         input logic x, v, fs, fe);
    check({who, ".x"}, 32'(x), 32'(exp.v ? exp.x : 1'b0));
    check({who, ".x_valid"}, 32'(v), 32'(exp.v));
    check({who, ".frame_start"}, 32'(fs), 32'(exp.fs));
    check({who, ".frame_end"}, 32'(fe), 32'(exp.fe));
  endtask

  task automatic step(input logic r,
                      input logic v,
                      input logic [7:0] d);
    logic xfer;
    @(negedge clk);
    chk_out("msb", cur_m, bm.x, bm.x_valid,
            bm.frame_start, bm.frame_end);
    chk_out("lsb", cur_l, bl.x, bl.x_valid,
            bl.frame_start, bl.frame_end);
    rst = r;
    din_valid = v;
    din = d;
    #1;
    check("msb.din_ready", 32'(bm.din_ready),
          32'(!r && q_m.size() == 0));
    check("lsb.din_ready", 32'(bl.din_ready),
          32'(!r && q_l.size() == 0));
    @(posedge clk);
    if (r) begin
      q_m.delete();
      q_l.delete();
      cur_m = '0;
      cur_l = '0;
    end else begin
      xfer = v && (q_m.size() == 0);
      if (xfer) begin
        for (int k = 0; k < FLEN; k++) begin
          q_m.push_back(frame_bit(d, 1'b1, k));
          q_l.push_back(frame_bit(d, 1'b0, k));
        end
      end
      cur_m = (q_m.size() != 0) ? q_m.pop_front() : '0;
      cur_l = (q_l.size() != 0) ? q_l.pop_front() : '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b1;
    din = 8'h00;
    cur_m = '0;
    cur_l = '0;
    @(posedge clk);

    // reset with valid held, then idle
    step(1, 1, 8'hA5);
    step(1, 1, 8'hA5);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    // single word
    step(0, 1, 8'hB1);
    for (int i = 0; i < FLEN + 2; i++) step(0, 0, 8'h00);

    // back-to-back with valid held
    step(0, 1, 8'hF0);
    for (int i = 0; i < FLEN; i++) step(0, 1, 8'h0F);
    for (int i = 0; i < FLEN + 2; i++) step(0, 0, 8'h00);

    // LSB-first instance sees 0x01
    step(0, 1, 8'h01);
    for (int i = 0; i < FLEN + 1; i++) step(0, 0, 8'h00);

    // parity samples
    step(0, 1, 8'h07);
    for (int i = 0; i < FLEN; i++) step(0, 1, 8'h03);
    for (int i = 0; i < FLEN + 1; i++) step(0, 0, 8'h00);

    // reset mid-frame, then a clean word
    step(0, 1, 8'hFF);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    step(0, 1, 8'hAA);
    for (int i = 0; i < FLEN + 2; i++) step(0, 0, 8'h00);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7),
           8'($urandom));
    end
    for (int i = 0; i < FLEN + 2; i++) step(0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
